// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, state/word types, xtime, and the stage's output payload.
package aes_pkg;

    localparam int unsigned AES_NR  = 10;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ROUND_W = 4;

    typedef logic [STATE_W-1:0] aes_state_t;
    typedef logic [WORD_W-1:0]  aes_word_t;

    typedef enum logic {
        NO_KEY = 1'b0,
        KEYED  = 1'b1
    } ark_fsm_t;

    typedef struct packed {
        aes_state_t         state;
        logic [ROUND_W-1:0] round;
        logic               last;
    } ark_out_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: S-box applied to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  aes_word_t word,
    output aes_word_t sub_word
);

    always_comb begin
        sub_word = '0;
        for (int b = 0; b < 4; b++) begin
            sub_word[8*b +: 8] = SBOX[word[8*b +: 8]];
        end
    end

endmodule

// File: rtl/add_round_key_stage.sv
// AddRoundKey execute stage with on-the-fly AES-128 key expansion, one round key per accepted state.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_load,
    input  logic [STATE_W-1:0] key_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic [ROUND_W-1:0] out_round,
    output logic               out_last
);

    ark_fsm_t           fsm_q;
    ark_fsm_t           fsm_d;
    aes_state_t         cipher_key_r;
    aes_state_t         rk_r;
    logic [ROUND_W-1:0] round_r;
    logic [7:0]         rcon_r;
    ark_out_t           out_q;
    logic               valid_q;

    aes_word_t          rot_w3;
    aes_word_t          sub_w3;
    aes_word_t          t_w;
    aes_word_t          w0_n;
    aes_word_t          w1_n;
    aes_word_t          w2_n;
    aes_word_t          w3_n;
    logic               accept;
    logic               at_last;

    // Next round key: S-box on rotated w3, then the 4-word XOR chain.
    assign rot_w3 = {rk_r[23:0], rk_r[31:24]};

    aes_sub_word u_sub_word (
        .word     (rot_w3),
        .sub_word (sub_w3)
    );

    assign t_w  = sub_w3 ^ {rcon_r, 24'h0};
    assign w0_n = rk_r[127:96] ^ t_w;
    assign w1_n = rk_r[95:64]  ^ w0_n;
    assign w2_n = rk_r[63:32]  ^ w1_n;
    assign w3_n = rk_r[31:0]   ^ w2_n;

    assign accept  = in_valid && in_ready;
    assign at_last = (round_r == ROUND_W'(NR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= NO_KEY;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        if (key_load) fsm_d = KEYED;
    end

    // key_load wins over a same-cycle input handshake.
    always_comb begin
        in_ready = 1'b0;
        if (fsm_q == KEYED && !key_load && (!valid_q || out_ready)) in_ready = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipher_key_r <= '0;
            rk_r         <= '0;
            round_r      <= '0;
            rcon_r       <= 8'h01;
            out_q        <= '0;
            valid_q      <= 1'b0;
        end else if (key_load) begin
            cipher_key_r <= key_in;
            rk_r         <= key_in;
            round_r      <= '0;
            rcon_r       <= 8'h01;
            valid_q      <= 1'b0;
        end else if (accept) begin
            out_q.state <= state_in ^ rk_r;
            out_q.round <= round_r;
            out_q.last  <= at_last;
            valid_q     <= 1'b1;
            if (at_last) begin
                rk_r    <= cipher_key_r;
                rcon_r  <= 8'h01;
                round_r <= '0;
            end else begin
                rk_r    <= {w0_n, w1_n, w2_n, w3_n};
                rcon_r  <= xtime(rcon_r);
                round_r <= round_r + ROUND_W'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign state_out = out_q.state;
    assign out_round = out_q.round;
    assign out_last  = out_q.last;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Self-checking bench for add_round_key_stage against a textbook AES-128 key-expansion model.
module tb_add_round_key_stage;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] key_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] state_out;
    logic [3:0]   out_round;
    logic         out_last;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [7:0]   sbox_m [256];
    logic [127:0] rk_m [11];
    bit           keyed_m = 1'b0;
    int           r_m = 0;
    bit           ev = 1'b0;
    logic [127:0] es = '0;
    int           er = 0;
    bit           el = 1'b0;

    add_round_key_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .out_round (out_round),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: GF inverse followed by the affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
    endfunction

    // Full 44-word key schedule, sliced into 11 round keys.
    function automatic void expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: check outputs mid-cycle, advance the model, then move to just after the next edge.
    task automatic step();
        bit rdy;
        @(negedge clk);
        rdy = keyed_m && !key_load && (!ev || out_ready);
        chk("in_ready", 128'(in_ready), 128'(rdy));
        chk("out_valid", 128'(out_valid), 128'(ev));
        if (ev) begin
            chk("state_out", state_out, es);
            chk("out_round", 128'(out_round), 128'(er));
            chk("out_last", 128'(out_last), 128'(el));
        end
        if (key_load) begin
            expand(key_in);
            keyed_m = 1'b1;
            ev      = 1'b0;
            r_m     = 0;
        end else if (in_valid && rdy) begin
            es  = state_in ^ rk_m[r_m];
            er  = r_m;
            el  = (r_m == 10);
            ev  = 1'b1;
            r_m = (r_m == 10) ? 0 : r_m + 1;
        end else if (ev && out_ready) begin
            ev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_key(input logic [127:0] k);
        key_load = 1'b1;
        key_in   = k;
        in_valid = 1'b0;
        step();
        key_load = 1'b0;
    endtask

    initial begin
        logic [127:0] k3;
        logic [127:0] s3;
        logic [3:0]   held_round;
        logic [127:0] held_state;

        build_sbox();

        // Reset values.
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_state_out", state_out, 128'(0));
        chk("rst_out_round", 128'(out_round), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // No key: in_ready stays low.
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // FIPS-197 key expansion through wrap-around.
        load_key(FIPS_KEY);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            state_in = '0;
            step();
            case (i)
                0:  chk("fips_rk0", state_out, FIPS_KEY);
                1:  chk("fips_rk1", state_out, 128'ha0fafe1788542cb123a339392a6c7605);
                10: begin
                    chk("fips_rk10", state_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
                    chk("fips_last", 128'(out_last), 128'(1));
                end
                11: begin
                    chk("wrap_state", state_out, FIPS_KEY);
                    chk("wrap_round", 128'(out_round), 128'(0));
                end
                default: ;
            endcase
        end

        // Round 0 on the FIPS plaintext.
        load_key(FIPS_KEY);
        in_valid = 1'b1;
        state_in = 128'h3243f6a8885a308d313198a2e0370734;
        step();
        chk("fips_round0", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

        // Backpressure for 5 cycles, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            state_in = rnd128();
            step();
            if (i == 0) begin
                held_round = out_round;
                held_state = state_out;
            end
        end
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_round_hold", 128'(out_round), 128'(held_round));
        chk("bp_state_hold", state_out, held_state);
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            state_in = rnd128();
            step();
        end

        // key_load mid-block at round 4.
        load_key(rnd128());
        in_valid = 1'b1;
        for (int i = 0; i < 20 && r_m != 4; i++) begin
            state_in = rnd128();
            step();
        end
        chk("kl_reach_round4", 128'(r_m), 128'(4));
        k3 = rnd128();
        key_load = 1'b1;
        key_in   = k3;
        state_in = rnd128();
        step();
        key_load = 1'b0;
        chk("kl_abort_valid", 128'(out_valid), 128'(0));
        s3 = rnd128();
        state_in = s3;
        step();
        chk("kl_new_round", 128'(out_round), 128'(0));
        chk("kl_new_state", state_out, s3 ^ k3);

        // Randomized traffic with occasional rekeying.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            state_in  = rnd128();
            key_load  = ($urandom % 50) == 0;
            key_in    = rnd128();
            step();
        end
        key_load = 1'b0;

        // Asynchronous reset while an output is pending.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        load_key(rnd128());
        in_valid = 1'b1;
        state_in = rnd128();
        step();
        chk("prerst_valid", 128'(out_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_state_out", state_out, 128'(0));
        chk("arst_out_round", 128'(out_round), 128'(0));
        chk("arst_out_last", 128'(out_last), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(0));
        keyed_m = 1'b0;
        ev      = 1'b0;
        r_m     = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            state_in = rnd128();
            step();
        end
        chk("post_rst_in_ready", 128'(in_ready), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
